// File: rtl/vga_timing_controller_if.sv
// Raster timing bundle between the VGA timing controller and its consumers.
// The controller takes the master side; the pixel path and bench take the slave side.
interface vga_timing_controller_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
    logic          pix_tick;
    logic          run;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [1:0]    h_phase;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_end;
    logic          frame_end;

    modport master (
        input  pix_tick, run,
        output hcount, vcount, h_phase,
        output hsync, vsync, video_on,
        output line_end, frame_end
    );

    modport slave (
        output pix_tick, run,
        input  hcount, vcount, h_phase,
        input  hsync, vsync, video_on,
        input  line_end, frame_end
    );
endinterface

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel/line counters, horizontal phase FSM and sync decode.
// Everything runs on clk; pix_tick only enables the counters.
module vga_timing_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    vga_timing_controller_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] HA_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VA_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
        $error("vga_timing_controller: every timing parameter must be >= 1");
    end

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } h_phase_e;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    h_phase_e      ph_q, ph_d;

    logic h_last, v_last, adv;

    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);
    assign adv    = bus.pix_tick & bus.run;

    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        ph_d = ph_q;
        if (!bus.run) begin
            h_d  = '0;
            v_d  = '0;
            ph_d = PH_ACTIVE;
        end else if (bus.pix_tick) begin
            h_d = h_last ? '0 : h_q + 1'b1;
            if (h_last)
                v_d = v_last ? '0 : v_q + 1'b1;
            // Phase moves on the tick that lands hcount on the next boundary.
            case (ph_q)
                PH_ACTIVE: if (h_q == HA_END - 1'b1) ph_d = PH_FRONT;
                PH_FRONT:  if (h_q == HS_BEG - 1'b1) ph_d = PH_SYNC;
                PH_SYNC:   if (h_q == HS_END - 1'b1) ph_d = PH_BACK;
                PH_BACK:   if (h_last)               ph_d = PH_ACTIVE;
                default:                             ph_d = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q  <= '0;
            v_q  <= '0;
            ph_q <= PH_ACTIVE;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            ph_q <= ph_d;
        end
    end

    logic hs_on, vs_on, line_end_w;

    assign hs_on      = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_on      = (v_q >= VS_BEG) && (v_q < VS_END);
    assign line_end_w = adv & h_last;

    assign bus.hcount    = h_q;
    assign bus.vcount    = v_q;
    assign bus.h_phase   = ph_q;
    assign bus.hsync     = (bus.run & hs_on) ? SYNC_POL : ~SYNC_POL;
    assign bus.vsync     = (bus.run & vs_on) ? SYNC_POL : ~SYNC_POL;
    assign bus.video_on  = bus.run & (h_q < HA_END) & (v_q < VA_END);
    assign bus.line_end  = line_end_w;
    assign bus.frame_end = line_end_w & v_last;
endmodule
